// File: rtl/clk_sw_pkg.sv
// Shared definitions for the clock-switch sequencing controller.
package clk_sw_pkg;

  localparam int NUM_REQ = 2;

  // Source encodings driven onto sel / cur_src
  localparam logic SRC_CLK0 = 1'b0;
  localparam logic SRC_CLK1 = 1'b1;

  // Controller states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Internal state made visible for observation
  typedef struct packed {
    logic [1:0] state;
    logic       rr_ptr;
  } dbg_t;

endpackage

// File: rtl/clk_switch_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; priority passes to the other requester after every grant.
module rr_arb2
  import clk_sw_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic               gnt_idx,
  output logic               gnt_vld,
  output logic               ptr
);

  // Pick the pointed-to requester if it is asking, otherwise the other one
  always_comb begin
    gnt_vld = |req;
    if (req[ptr]) begin
      gnt_idx = ptr;
    end else begin
      gnt_idx = ~ptr;
    end
  end

  // Move priority away from whoever was just granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance && gnt_vld) begin
      ptr <= ~gnt_idx;
    end
  end

endmodule

// File: rtl/clk_switch_ctrl.sv
// Sequencing controller for the glitch-free clock switch.
// Handshake: a requester holds req_vld (and req_tgt) as a level until it sees
// a one-cycle req_ack for its index; req_vld is only sampled in IDLE, and once
// granted the sequence always runs to its ack even if the request is withdrawn.
module clk_switch_ctrl
  import clk_sw_pkg::*;
#(
  parameter int SETTLE_CYC = 8,
  parameter int DWELL_CYC  = 16,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_vld,
  input  logic [NUM_REQ-1:0] req_tgt,
  output logic [NUM_REQ-1:0] req_ack,
  output logic               sel,
  output logic               cur_src,
  output logic               busy,
  output dbg_t               dbg
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL_CYC - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             win_idx;
  logic             win_sw;
  logic             gnt_idx;
  logic             gnt_vld;
  logic             rr_ptr;
  logic             gnt_tgt;
  logic             grant;

  // Arbitration only advances on an actual grant taken in IDLE
  assign grant   = (state == ST_IDLE) && gnt_vld;
  assign gnt_tgt = req_tgt[gnt_idx];

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_vld),
    .advance (grant),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .ptr     (rr_ptr)
  );

  // Main sequencer: grant, settle after a sel change, acknowledge, then dwell
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sel     <= SRC_CLK0;
      cur_src <= SRC_CLK0;
      win_idx <= 1'b0;
      win_sw  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            win_idx <= gnt_idx;
            if (gnt_tgt == cur_src) begin
              win_sw <= 1'b0;
              state  <= ST_ACK;
            end else begin
              win_sw <= 1'b1;
              sel    <= gnt_tgt;
              cnt    <= SETTLE_LD;
              state  <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            cur_src <= sel;
            state   <= ST_ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ACK: begin
          // Same-source requests never touched sel, so no dwell is needed
          if (win_sw) begin
            cnt   <= DWELL_LD;
            state <= ST_HOLD;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // Acknowledge decoded from registered state so it is a clean one-cycle pulse
  always_comb begin
    req_ack = '0;
    if (state == ST_ACK) begin
      req_ack[win_idx] = 1'b1;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg.state  = state;
  assign dbg.rr_ptr = rr_ptr;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: directed sequences, acks checked by a scoreboard monitor.
module tb_clk_switch_ctrl;
  import clk_sw_pkg::*;

  localparam int SC = 8;
  localparam int DC = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_vld = 2'b00;
  logic [1:0] req_tgt = 2'b00;
  logic [1:0] req_ack;
  logic       sel;
  logic       cur_src;
  logic       busy;
  dbg_t       dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected ack entries: {cycle[31:0], ack[1:0], cur_src, sel}
  logic [35:0] exp_q[$];

  clk_switch_ctrl #(.SETTLE_CYC(SC), .DWELL_CYC(DC), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_tgt (req_tgt),
    .req_ack (req_ack),
    .sel     (sel),
    .cur_src (cur_src),
    .busy    (busy),
    .dbg     (dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ack(input int at_cyc, input logic [1:0] ack, input logic src, input logic s);
    exp_q.push_back({32'(at_cyc), ack, src, s});
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Assert reset (called at a negedge), present the given request, release after hold cycles
  task automatic do_reset(input int hold, input logic [1:0] vld, input logic [1:0] tgt, output int rel);
    rst = 1'b1;
    req_vld = vld;
    req_tgt = tgt;
    #1;
    check("rst_sel_async", 32'(sel), 32'(0));
    check("rst_ack_async", 32'(req_ack), 32'(0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rst_sel", 32'(sel), 32'(0));
      check("rst_cur_src", 32'(cur_src), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_ack", 32'(req_ack), 32'(0));
      check("rst_ptr", 32'(dbg.rr_ptr), 32'(0));
    end
    rst = 1'b0;
    rel = cyc;
  endtask

  // Monitor: every ack pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && req_ack != 2'b00) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got req_ack=%b at cycle %0d, required none", req_ack, cyc);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        check("ack_cycle", 32'(cyc), e[35:4]);
        check("ack_bits", 32'(req_ack), 32'(e[3:2]));
        check("ack_cur_src", 32'(cur_src), 32'(e[1]));
        check("ack_sel", 32'(sel), 32'(e[0]));
      end
    end
  end

  // Directed stimulus
  initial begin
    int rel;
    int g;
    int g2;
    int g3;

    // Reset with a pending 0->1 request, then the switch and its dwell
    @(negedge clk);
    do_reset(5, 2'b01, 2'b01, rel);
    g = rel + 1;
    expect_ack(g + SC, 2'b01, 1'b1, 1'b1);
    wait_until(g);
    check("sw_sel_at_grant", 32'(sel), 32'(1));
    check("sw_busy", 32'(busy), 32'(1));
    check("sw_state_settle", 32'(dbg.state), 32'(ST_SETTLE));
    check("sw_cur_src_before", 32'(cur_src), 32'(0));
    wait_until(g + SC - 1);
    check("sw_no_early_ack", 32'(req_ack), 32'(0));
    check("sw_cur_src_late", 32'(cur_src), 32'(0));
    wait_until(g + SC);
    req_vld = 2'b00;

    // Request from requester 1 raised during HOLD is held off until IDLE
    wait_until(g + SC + 4);
    req_vld = 2'b10;
    req_tgt = 2'b00;
    wait_until(g + SC + DC);
    check("hold_busy", 32'(busy), 32'(1));
    check("hold_sel", 32'(sel), 32'(1));
    check("hold_state", 32'(dbg.state), 32'(ST_HOLD));
    wait_until(g + SC + DC + 1);
    check("hold_end_idle", 32'(busy), 32'(0));
    check("hold_end_sel", 32'(sel), 32'(1));
    g2 = g + SC + DC + 2;
    expect_ack(g2 + SC, 2'b10, 1'b0, 1'b0);
    wait_until(g2);
    check("sw2_sel", 32'(sel), 32'(0));
    wait_until(g2 + SC);
    req_vld = 2'b00;

    // Same-source request: fast ack, one busy cycle
    wait_until(g2 + SC + DC + 1);
    check("fast_idle_before", 32'(busy), 32'(0));
    req_vld = 2'b10;
    req_tgt = 2'b00;
    g3 = g2 + SC + DC + 2;
    expect_ack(g3, 2'b10, 1'b0, 1'b0);
    wait_until(g3);
    check("fast_busy", 32'(busy), 32'(1));
    req_vld = 2'b00;
    wait_until(g3 + 1);
    check("fast_busy_one_cycle", 32'(busy), 32'(0));
    check("fast_sel", 32'(sel), 32'(0));
    check("fast_ptr", 32'(dbg.rr_ptr), 32'(0));

    // Simultaneous requests from reset: 0 switches, 1 then gets a same-source ack
    do_reset(5, 2'b11, 2'b11, rel);
    g = rel + 1;
    expect_ack(g + SC, 2'b01, 1'b1, 1'b1);
    wait_until(g);
    check("sim_ptr_moved", 32'(dbg.rr_ptr), 32'(1));
    wait_until(g + SC);
    req_vld = 2'b10;
    g2 = g + SC + DC + 2;
    expect_ack(g2, 2'b10, 1'b1, 1'b1);
    wait_until(g2);
    check("sim_loser_busy", 32'(busy), 32'(1));
    req_vld = 2'b00;
    wait_until(g2 + 1);
    check("sim_no_hold", 32'(busy), 32'(0));
    check("sim_sel_kept", 32'(sel), 32'(1));

    // Reset in the 4th SETTLE cycle, then the request is replayed
    do_reset(2, 2'b01, 2'b01, rel);
    g = rel + 1;
    wait_until(g + 3);
    check("abort_state", 32'(dbg.state), 32'(ST_SETTLE));
    check("abort_sel_before", 32'(sel), 32'(1));
    do_reset(3, 2'b01, 2'b01, rel);
    g = rel + 1;
    expect_ack(g + SC, 2'b01, 1'b1, 1'b1);
    wait_until(g);
    check("replay_sel", 32'(sel), 32'(1));
    wait_until(g + SC);
    req_vld = 2'b00;
    wait_until(g + SC + DC + 1);
    check("replay_idle", 32'(busy), 32'(0));

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
